// File: rtl/mdu_sequencer_pkg.sv
// Shared MDU definitions: op encodings (match the controller's MDU_Op), FSM states, default latencies.
// Optional feature macro: MDU_MADD_EN (ops 4/5 become legal accumulate ops).
package mdu_sequencer_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MADD  = 3'd4;
    localparam logic [2:0] MDU_MADDU = 3'd5;

    localparam int MDU_MULT_CYCLES_DEF = 5;
    localparam int MDU_DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdu_state_e;

    function automatic logic mdu_op_legal(input logic [2:0] op);
`ifdef MDU_MADD_EN
        return (op <= MDU_MADDU);
`else
        return (op <= MDU_DIVU);
`endif
    endfunction

    function automatic logic mdu_op_is_div(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit product / quotient+remainder (plus optional accumulate) from latched operands.
// Latency: 0 (pure logic). Backpressure: none; the sequencer decides when to commit. Macro: MDU_MADD_EN.
module mdu_arith
    import mdu_sequencer_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
`ifdef MDU_MADD_EN
    input  logic [31:0] acc_hi,
    input  logic [31:0] acc_lo,
`endif
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        res_vld
);

    logic        is_signed;
    logic        is_div;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] prod;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [63:0] mul_res;

    assign is_signed = (op == MDU_MULT) || (op == MDU_DIV) || (op == MDU_MADD);
    assign is_div    = mdu_op_is_div(op);

    // One multiplier for both signednesses: sign- or zero-extend to 64 bits.
    assign mul_a = {{32{is_signed & a[31]}}, a};
    assign mul_b = {{32{is_signed & b[31]}}, b};
    assign prod  = mul_a * mul_b;

    // Magnitude divide keeps truncation toward zero and remainder sign = dividend sign.
    assign a_neg  = is_signed & a[31];
    assign b_neg  = is_signed & b[31];
    assign a_mag  = a_neg ? (32'd0 - a) : a;
    assign b_mag  = b_neg ? (32'd0 - b) : b;
    assign b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign q_mag  = a_mag / b_safe;
    assign r_mag  = a_mag % b_safe;
    assign quot   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign rem    = a_neg ? (32'd0 - r_mag) : r_mag;

`ifdef MDU_MADD_EN
    assign mul_res = ((op == MDU_MADD) || (op == MDU_MADDU)) ? (prod + {acc_hi, acc_lo}) : prod;
`else
    assign mul_res = prod;
`endif

    assign res_hi  = is_div ? rem  : mul_res[63:32];
    assign res_lo  = is_div ? quot : mul_res[31:0];
    assign res_vld = !(is_div && (b == 32'd0));

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle mult/div sequencer owning HI/LO and the D-stage MDU stall. Macro: MDU_MADD_EN.
// Latency: start at edge k -> busy k+1..k+N, HI/LO updated at edge k+N. Backpressure: stall_o holds MDU-class D instrs.
module mdu_sequencer
    import mdu_sequencer_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        hi_we_i,
    input  logic        lo_we_i,
    input  logic        md_d_i,
    output logic        busy_o,
    output logic        stall_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam logic [4:0] MULT_LAT = 5'(MULT_CYCLES);
    localparam logic [4:0] DIV_LAT  = 5'(DIV_CYCLES);

    mdu_state_e  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        load;
    logic        commit;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        res_vld;

    mdu_arith u_arith (
        .op      (op_q),
        .a       (a_q),
        .b       (b_q),
`ifdef MDU_MADD_EN
        .acc_hi  (hi_q),
        .acc_lo  (lo_q),
`endif
        .res_hi  (res_hi),
        .res_lo  (res_lo),
        .res_vld (res_vld)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q <= MDU_MULT;
            a_q  <= 32'd0;
            b_q  <= 32'd0;
        end else if (load) begin
            op_q <= op_i;
            a_q  <= a_i;
            b_q  <= b_i;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        commit  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (mdu_op_legal(op_i)) begin
                        load    = 1'b1;
                        state_d = RUN;
                        cnt_d   = mdu_op_is_div(op_i) ? DIV_LAT : MULT_LAT;
                    end
                end else begin
                    // mthi/mtlo only land when no start shares the cycle
                    if (hi_we_i) hi_d = a_i;
                    if (lo_we_i) lo_d = a_i;
                end
            end
            RUN: begin
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end
                if (commit && res_vld) begin
                    hi_d = res_hi;
                    lo_d = res_lo;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o  = (state_q == RUN);
    assign stall_o = md_d_i & (start_i | busy_o);
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

endmodule
